// File: rtl/bcd_to_xs3_seq.sv
// bcd_to_xs3_seq: sequential multi-digit BCD-to-Excess-3 encoder.
//
// One packed BCD word is taken per valid/ready handshake, converted one digit per clock
// (least-significant digit first, xs3 = d + 3), then the result is held until the sink
// accepts it. Digits above 9 encode as 4'h0 and set their bit in err_mask.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   in_bcd holds a word to convert
//   in_ready   out  block accepts a word this cycle (IDLE only)
//   in_bcd     in   packed BCD, digit i = in_bcd[4i+3:4i]
//   out_valid  out  out_xs3 / err_mask / out_err are valid (DONE)
//   out_ready  in   sink accepts the result this cycle
//   out_xs3    out  packed Excess-3 result, same digit order
//   err_mask   out  bit i set: input digit i was > 9
//   out_err    out  OR of err_mask
//   busy       out  high while converting or holding a result
module bcd_to_xs3_seq #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_xs3,
    output logic [DIGITS-1:0]     err_mask,
    output logic                  out_err,
    output logic                  busy
);

    localparam int unsigned CntW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StDone
    } state_e;

    state_e                 state_q;
    logic [CntW-1:0]        cnt_q;
    logic [4*DIGITS-1:0]    src_q;
    logic [4*DIGITS-1:0]    xs3_q, xs3_d;
    logic [DIGITS-1:0]      mask_q, mask_d;
    logic                   err_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic                   busy_q;

    logic [3:0]             cur_digit;
    logic [3:0]             cur_xs3;
    logic                   digit_bad;

    // Convert the digit selected by the counter and merge it into the result slot.
    always_comb begin
        cur_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q == CntW'(i)) begin
                cur_digit = src_q[4*i +: 4];
            end
        end
        digit_bad = (cur_digit > 4'd9);
        cur_xs3   = digit_bad ? 4'h0 : (cur_digit + 4'd3);

        xs3_d  = xs3_q;
        mask_d = mask_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q == CntW'(i)) begin
                xs3_d[4*i +: 4] = cur_xs3;
                mask_d[i]       = digit_bad;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            src_q       <= '0;
            xs3_q       <= '0;
            mask_q      <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        src_q      <= in_bcd;
                        xs3_q      <= '0;
                        mask_q     <= '0;
                        err_q      <= 1'b0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= StConv;
                    end
                end
                StConv: begin
                    xs3_q  <= xs3_d;
                    mask_q <= mask_d;
                    // Flag tracks the mask written on the same edge.
                    err_q  <= |mask_d;
                    if (cnt_q == CntW'(DIGITS - 1)) begin
                        cnt_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_xs3   = xs3_q;
    assign err_mask  = mask_q;
    assign out_err   = err_q;
    assign busy      = busy_q;

endmodule
